// File: rtl/aes_enc_pipe_ctrl_if.sv
// Plaintext-in / ciphertext-out valid/ready bundle for aes_enc_pipe_ctrl.
// master drives blocks in and consumes results; slave is the controller.
interface aes_enc_pipe_ctrl_if #(
  parameter int TAG_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/aes_enc_pipe_ctrl.sv
// Flow control around the fixed-latency AES-128 encrypt pipeline:
// credit-limited issue, tag tracking, result FIFO, key-change drain.
module aes_enc_pipe_ctrl #(
  parameter int PIPE_LAT   = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  aes_enc_pipe_ctrl_if.slave  bus,
  output logic [127:0]        pipe_plain_text,
  input  logic [127:0]        pipe_cipher_text,
  input  logic                key_chg_req,
  output logic                key_chg_gnt,
  output logic                busy,
  output logic [31:0]         blk_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, GRANT} state_e;

  state_e              state_q;
  logic                gnt_q;
  logic [PIPE_LAT-1:0] vsr_q;
  logic [TAG_W-1:0]    tsr_q [PIPE_LAT];
  logic [CW-1:0]       credit_q, credit_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       wp_q, rp_q;
  logic [127:0]        dmem [FIFO_DEPTH];
  logic [TAG_W-1:0]    tmem [FIFO_DEPTH];
  logic [31:0]         blk_q;
  logic                acc, push, pop;

  // Registered credit only: a pop frees space one cycle later.
  assign bus.in_ready = rst_n & (state_q == RUN) & (credit_q < FULL);
  assign acc          = bus.in_valid & bus.in_ready;
  assign push         = vsr_q[PIPE_LAT-1];
  assign pop          = bus.out_valid & bus.out_ready;

  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_data  = dmem[rp_q];
  assign bus.out_tag   = tmem[rp_q];

  assign pipe_plain_text = bus.in_data;
  assign key_chg_gnt     = gnt_q;
  assign busy            = (credit_q != '0);
  assign blk_count       = blk_q;

  always_comb begin
    credit_d = credit_q;
    if (acc & ~pop)
      credit_d = credit_q + CW'(1);
    else if (~acc & pop)
      credit_d = credit_q - CW'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push & ~pop)
      cnt_d = cnt_q + CW'(1);
    else if (~push & pop)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsr_q    <= '0;
      credit_q <= '0;
      cnt_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      blk_q    <= '0;
    end else begin
      vsr_q[0] <= acc;
      for (int i = 1; i < PIPE_LAT; i++)
        vsr_q[i] <= vsr_q[i-1];
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      if (push)
        wp_q <= wp_q + AW'(1);
      if (pop) begin
        rp_q  <= rp_q + AW'(1);
        blk_q <= blk_q + 32'd1;
      end
    end
  end

  // Tags and FIFO storage need no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    tsr_q[0] <= bus.in_tag;
    for (int i = 1; i < PIPE_LAT; i++)
      tsr_q[i] <= tsr_q[i-1];
    if (push) begin
      dmem[wp_q] <= pipe_cipher_text;
      tmem[wp_q] <= tsr_q[PIPE_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      gnt_q   <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (key_chg_req)
            state_q <= DRAIN;
        end
        DRAIN: begin
          if (!key_chg_req) begin
            state_q <= RUN;
          end else if (vsr_q == '0) begin
            state_q <= GRANT;
            gnt_q   <= 1'b1;
          end
        end
        GRANT: begin
          if (!key_chg_req) begin
            state_q <= RUN;
            gnt_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= RUN;
          gnt_q   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_enc_pipe_ctrl.sv
// Directed bench for aes_enc_pipe_ctrl with a 10-stage stand-in for
// encrypt_top and an in-order scoreboard on the output port.
module tb_aes_enc_pipe_ctrl;
  localparam int TAG_W = 4;
  localparam int PL    = 10;
  localparam int FD    = 16;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct packed {
    logic [127:0]     d;
    logic [TAG_W-1:0] t;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] ppt, pct;
  logic         req, gnt, busy;
  logic [31:0]  blk;
  logic [127:0] key;
  logic [127:0] stg [PL];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           exp_blk = 0;
  exp_t         sbq [$];
  exp_t         e;

  aes_enc_pipe_ctrl_if #(.TAG_W(TAG_W)) bus ();

  aes_enc_pipe_ctrl #(
    .PIPE_LAT(PL), .FIFO_DEPTH(FD), .TAG_W(TAG_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .pipe_plain_text  (ppt),
    .pipe_cipher_text (pct),
    .key_chg_req      (req),
    .key_chg_gnt      (gnt),
    .busy             (busy),
    .blk_count        (blk)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: real FIPS-197 answer for the known vector,
  // otherwise a key-dependent scramble.
  function automatic logic [127:0] enc(input logic [127:0] k,
                                       input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT)
      return FIPS_CT;
    return {p[63:0], p[127:64]} ^ k ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    stg[0] <= enc(key, ppt);
    for (int i = 1; i < PL; i++)
      stg[i] <= stg[i-1];
  end
  assign pct = stg[PL-1];

  task automatic chk(input string nm, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_vs_credit", busy, sbq.size() != 0);
      if (sbq.size() >= FD)
        chk("ready_at_full", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          chk("out_valid_spurious", bus.out_valid, 0);
        end else begin
          e = sbq.pop_front();
          chk("out_data", bus.out_data, e.d);
          chk("out_tag", bus.out_tag, e.t);
          exp_blk++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.d = enc(key, bus.in_data);
        e.t = bus.in_tag;
        sbq.push_back(e);
      end
    end
  end

  initial begin
    int acc_cyc, lat, nlow, nacc, gcyc, nhi, nstale;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    req           = 1'b0;
    key           = FIPS_KEY;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blk", blk, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);

    // FIPS-197 single block
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = FIPS_PT;
    bus.in_tag    = 4'd5;
    @(negedge clk);
    acc_cyc = cyc;
    chk("fips_acc", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    chk("fips_lat", lat, 11);
    chk("fips_data", bus.out_data, FIPS_CT);
    chk("fips_tag", bus.out_tag, 5);
    step();
    step();
    chk("fips_blk", blk, 1);

    // 40 back-to-back blocks, full rate
    nlow = 0;
    for (int i = 0; i < 40; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {4{32'(i * 7919 + 3)}};
      bus.in_tag   = TAG_W'(i % 16);
      #1;
      if (bus.in_ready !== 1'b1)
        nlow++;
      step();
    end
    bus.in_valid = 1'b0;
    repeat (10) step();
    chk("stream_blk_a", blk, 40);
    step();
    chk("stream_blk_b", blk, 41);
    chk("stream_ready_low", nlow, 0);

    // backpressure: exactly FD accepts
    bus.out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 30; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {4{32'(i + 32'h1000)}};
      bus.in_tag   = TAG_W'(i % 16);
      #1;
      if (bus.in_ready === 1'b1)
        nacc++;
      step();
    end
    chk("bp_accepts", nacc, 16);
    chk("bp_ready_full", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_busy", busy, 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_pop_cyc", bus.in_ready, 0);
    step();
    chk("bp_ready_after", bus.in_ready, 1);
    repeat (20) step();
    chk("bp_blk", blk, 57);
    chk("bp_busy_end", busy, 0);
    chk("bp_ov_end", bus.out_valid, 0);

    // key change after 5 blocks
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {4{32'(i + 32'h2000)}};
      bus.in_tag   = TAG_W'(i);
      if (i == 4)
        req = 1'b1;
      step();
    end
    bus.in_data = {4{32'h3000}};
    bus.in_tag  = 4'd9;
    #1;
    chk("kc_ready_drop", bus.in_ready, 0);
    gcyc = -1;
    nhi  = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (gnt === 1'b1) begin
        gcyc = i;
        break;
      end
      if (bus.in_ready !== 1'b0)
        nhi++;
    end
    chk("kc_gnt_lat", gcyc, 11);
    chk("kc_ready_drain", nhi, 0);
    chk("kc_ready_grant", bus.in_ready, 0);
    chk("kc_busy_grant", busy, 0);
    chk("kc_blk", blk, 62);
    key = KEY_B;
    req = 1'b0;
    step();
    chk("kc_gnt_drop", gnt, 0);
    chk("kc_ready_run", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1)
        break;
    end
    chk("kc_new_key", bus.out_data, enc(KEY_B, {4{32'h3000}}));
    chk("kc_new_tag", bus.out_tag, 9);
    repeat (3) step();

    // reset with 7 in flight and 3 buffered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {4{32'(i + 32'h4000)}};
      bus.in_tag   = TAG_W'(i);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("mr_pre_ov", bus.out_valid, 1);
    rst_n = 1'b0;
    sbq.delete();
    exp_blk = 0;
    #1;
    chk("mr_ov", bus.out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_blk", blk, 0);
    chk("mr_ready", bus.in_ready, 0);
    repeat (2) step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    nstale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0)
        nstale++;
    end
    chk("mr_stale", nstale, 0);
    step();
    key          = FIPS_KEY;
    bus.in_valid = 1'b1;
    bus.in_data  = FIPS_PT;
    bus.in_tag   = 4'd5;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1)
        break;
    end
    chk("mr_fips_data", bus.out_data, FIPS_CT);
    chk("mr_fips_tag", bus.out_tag, 5);
    step();
    chk("mr_blk_after", blk, 1);

    // full FIFO with out_ready toggling
    bus.out_ready = 1'b0;
    for (int i = 0; i < 120; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {4{32'(i + 32'h5000)}};
      bus.in_tag   = TAG_W'(i % 16);
      if (i >= 20)
        bus.out_ready = i[0];
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (40) step();
    chk("tog_busy", busy, 0);
    chk("tog_ov", bus.out_valid, 0);
    chk("tog_blk", blk, exp_blk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
